// File: rtl/scope_pkg.sv
// rtl/scope_pkg.sv - shared state encoding, register map and constants for the scope capture controller
package scope_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_LEVEL    = 3'd2;
  localparam logic [2:0] REG_POST_LEN = 3'd3;
  localparam logic [2:0] REG_DATA     = 3'd4;
  localparam logic [2:0] REG_RD_PTR   = 3'd5;
  localparam logic [2:0] REG_START    = 3'd6;

  localparam int CTRL_ARM   = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_SLOPE = 2;
  localparam int CTRL_FORCE = 3;

  localparam logic [15:0] LEVEL_RST = 16'h8000;

endpackage

// File: rtl/scope_trig_detect.sv
// rtl/scope_trig_detect.sv - level/slope trigger detector with forced-trigger request
module scope_trig_detect (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        en,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  input  logic [15:0] level,
  input  logic        slope,
  input  logic        force_req,
  output logic        trig
);

  logic [15:0] prev_q, prev_d;
  logic        prev_vld_q, prev_vld_d;
  logic        force_q, force_d;
  logic        level_hit;

  // Crossing test between the previous stored sample and the current one.
  always_comb begin
    level_hit = 1'b0;
    if (slope) begin
      level_hit = (prev_q > level) && (sample_data <= level);
    end else begin
      level_hit = (prev_q < level) && (sample_data >= level);
    end
  end

  // A level crossing needs a real previous sample; a pending force needs none.
  assign trig = en && sample_valid && (force_q || (prev_vld_q && level_hit));

  // Track the last sample stored while waiting, and hold a force request until a sample consumes it.
  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    force_d    = force_q;
    if (en && sample_valid) begin
      prev_d     = sample_data;
      prev_vld_d = 1'b1;
    end
    if (trig) begin
      force_d = 1'b0;
    end
    if (force_req) begin
      force_d = 1'b1;
    end
    if (clr) begin
      prev_vld_d = 1'b0;
      force_d    = 1'b0;
    end
  end

  // Detector state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= 16'h0000;
      prev_vld_q <= 1'b0;
      force_q    <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      force_q    <= force_d;
    end
  end

endmodule

// File: rtl/scope_capture_ctrl.sv
// rtl/scope_capture_ctrl.sv - pre/post-trigger capture sequencer with Avalon-MM register bank
module scope_capture_ctrl
  import scope_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [2:0]    avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  output logic [31:0]   avs_readdata,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          irq
);

  localparam int            DEPTH    = 1 << AW;
  localparam logic [AW-1:0] PTR_MAX  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] POST_RST = AW'(DEPTH / 2);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] pre_cnt_q, pre_cnt_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic [AW-1:0] post_len_q, post_len_d;
  logic [AW-1:0] post_len_lat_q, post_len_lat_d;
  logic [AW-1:0] trig_idx_q, trig_idx_d;
  logic [AW-1:0] start_idx_q, start_idx_d;
  logic [DW-1:0] level_q, level_d;
  logic          slope_q, slope_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          irq_q, irq_d;

  logic          wr_ctrl, do_abort, do_arm, storing;
  logic          trig_en, force_req, trig;
  logic [AW-1:0] pre_target, arm_target;

  // ABORT beats ARM in the same write; ARM is only honoured while not capturing.
  assign wr_ctrl    = avs_write && (avs_address == REG_CTRL);
  assign do_abort   = wr_ctrl && avs_writedata[CTRL_ABORT];
  assign do_arm     = wr_ctrl && avs_writedata[CTRL_ARM] && !do_abort &&
                      ((state_q == S_IDLE) || (state_q == S_DONE));
  assign storing    = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign trig_en    = (state_q == S_WAIT) && !do_abort;
  assign force_req  = wr_ctrl && avs_writedata[CTRL_FORCE] && trig_en;
  assign pre_target = PTR_MAX - post_len_lat_q;
  assign arm_target = PTR_MAX - post_len_q;

  assign mem_we       = sample_valid && storing && !do_abort;
  assign mem_waddr    = wr_ptr_q;
  assign mem_wdata    = sample_data;
  assign mem_raddr    = rd_ptr_q;
  assign irq          = irq_q;
  assign avs_readdata = rdata_q;

  scope_trig_detect u_trig (
    .clk          (clk),
    .reset_n      (reset_n),
    .clr          (do_arm),
    .en           (trig_en),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .level        (level_q),
    .slope        (slope_q),
    .force_req    (force_req),
    .trig         (trig)
  );

  // Capture sequencing: ring fill, trigger wait, post count; CTRL transitions override.
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    pre_cnt_d      = pre_cnt_q;
    post_cnt_d     = post_cnt_q;
    post_len_lat_d = post_len_lat_q;
    trig_idx_d     = trig_idx_q;
    start_idx_d    = start_idx_q;
    if (mem_we) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    case (state_q)
      S_PRE: begin
        if (mem_we) begin
          pre_cnt_d = pre_cnt_q + PTR_ONE;
          if (pre_cnt_d == pre_target) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (trig) begin
          trig_idx_d = wr_ptr_q;
          post_cnt_d = '0;
          if (post_len_lat_q == '0) begin
            state_d     = S_DONE;
            start_idx_d = wr_ptr_d;
          end else begin
            state_d = S_POST;
          end
        end
      end
      S_POST: begin
        if (mem_we) begin
          post_cnt_d = post_cnt_q + PTR_ONE;
          if (post_cnt_d == post_len_lat_q) begin
            state_d     = S_DONE;
            start_idx_d = wr_ptr_d;
          end
        end
      end
      default: begin
      end
    endcase
    if (do_arm) begin
      wr_ptr_d       = '0;
      pre_cnt_d      = '0;
      post_len_lat_d = post_len_q;
      state_d        = (arm_target == '0) ? S_WAIT : S_PRE;
    end
    if (do_abort) begin
      state_d = S_IDLE;
    end
    irq_d = (state_d == S_DONE);
  end

  // Register bank: writes to config registers, registered read mux, DATA auto-increment.
  always_comb begin
    level_d    = level_q;
    post_len_d = post_len_q;
    slope_d    = slope_q;
    rd_ptr_d   = rd_ptr_q;
    rdata_d    = rdata_q;
    if (avs_write) begin
      case (avs_address)
        REG_CTRL:     slope_d = avs_writedata[CTRL_SLOPE];
        REG_LEVEL:    level_d = avs_writedata[DW-1:0];
        REG_POST_LEN: post_len_d = (avs_writedata > {{(32-AW){1'b0}}, PTR_MAX}) ?
                                   PTR_MAX : avs_writedata[AW-1:0];
        REG_RD_PTR:   rd_ptr_d = avs_writedata[AW-1:0];
        default: begin
        end
      endcase
    end
    if (avs_read) begin
      case (avs_address)
        REG_STATUS:   rdata_d = {{(16-AW){1'b0}}, trig_idx_q, 12'h000,
                                 (state_q == S_DONE), state_q};
        REG_LEVEL:    rdata_d = {{(32-DW){1'b0}}, level_q};
        REG_POST_LEN: rdata_d = {{(32-AW){1'b0}}, post_len_q};
        REG_DATA: begin
          rdata_d  = {{(32-DW){1'b0}}, mem_rdata};
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        REG_RD_PTR:   rdata_d = {{(32-AW){1'b0}}, rd_ptr_q};
        REG_START:    rdata_d = {{(32-AW){1'b0}}, start_idx_q};
        default:      rdata_d = 32'h0000_0000;
      endcase
    end
  end

  // All controller state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      pre_cnt_q      <= '0;
      post_cnt_q     <= '0;
      post_len_q     <= POST_RST;
      post_len_lat_q <= POST_RST;
      trig_idx_q     <= '0;
      start_idx_q    <= '0;
      level_q        <= LEVEL_RST;
      slope_q        <= 1'b0;
      rdata_q        <= 32'h0000_0000;
      irq_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      pre_cnt_q      <= pre_cnt_d;
      post_cnt_q     <= post_cnt_d;
      post_len_q     <= post_len_d;
      post_len_lat_q <= post_len_lat_d;
      trig_idx_q     <= trig_idx_d;
      start_idx_q    <= start_idx_d;
      level_q        <= level_d;
      slope_q        <= slope_d;
      rdata_q        <= rdata_d;
      irq_q          <= irq_d;
    end
  end

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// tb/tb_scope_capture_ctrl.sv - self-checking bench for scope_capture_ctrl
module tb_scope_capture_ctrl;

  localparam int D = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  avs_address = 3'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = 16'd0;
  logic        mem_we;
  logic [9:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic [9:0]  mem_raddr;
  logic [15:0] mem_rdata;
  logic        irq;

  logic [15:0] ram [0:D-1];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  scope_capture_ctrl #(.AW(10), .DW(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .mem_raddr     (mem_raddr),
    .mem_rdata     (mem_rdata),
    .irq           (irq)
  );

  // external simple dual-port RAM with registered read
  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_wdata;
    mem_rdata <= ram[mem_raddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: phase 0 idle,1 pre,2 wait,3 post,4 done
  int          m_phase, m_nstored, m_target, m_plat, m_post, m_prev;
  int          m_level, m_plen, m_rd, m_start, m_trig;
  bit          m_have_prev, m_force, m_slope, m_rchk;
  logic [31:0] m_rdata;
  logic [15:0] m_mem [0:D-1];

  task automatic model_reset();
    m_phase = 0; m_nstored = 0; m_target = 0; m_plat = D/2; m_post = 0; m_prev = 0;
    m_level = 16'h8000; m_plen = D/2; m_rd = 0; m_start = 0; m_trig = 0;
    m_have_prev = 0; m_force = 0; m_slope = 0; m_rchk = 1; m_rdata = 0;
  endtask

  task automatic model_step();
    bit wc, ab, arm, st, hit;
    int a, s, ph0;
    ph0 = m_phase;
    wc  = avs_write && (avs_address == 3'd0);
    ab  = wc && avs_writedata[1];
    arm = wc && avs_writedata[0] && !ab && (ph0 == 0 || ph0 == 4);
    st  = sample_valid && ph0 >= 1 && ph0 <= 3 && !ab;
    m_rchk = avs_read;
    if (avs_read) begin
      case (avs_address)
        3'd1: m_rdata = m_trig * 65536 + (ph0 == 4 ? 8 : 0) + ph0;
        3'd2: m_rdata = m_level;
        3'd3: m_rdata = m_plen;
        3'd4: begin m_rdata = {16'h0, m_mem[m_rd]}; m_rd = (m_rd + 1) % D; end
        3'd5: m_rdata = m_rd;
        3'd6: m_rdata = m_start;
        default: m_rdata = 0;
      endcase
    end
    if (st) begin
      a = m_nstored % D;
      s = int'(sample_data);
      m_mem[a] = sample_data;
      if (ph0 == 1) begin
        if (m_nstored + 1 == m_target) m_phase = 2;
      end else if (ph0 == 2) begin
        if (m_slope) hit = m_prev > m_level && s <= m_level;
        else         hit = m_prev < m_level && s >= m_level;
        hit = m_force || (m_have_prev && hit);
        m_prev = s; m_have_prev = 1;
        if (hit) begin
          m_force = 0; m_trig = a; m_post = 0;
          if (m_plat == 0) begin m_phase = 4; m_start = (a + 1) % D; end
          else m_phase = 3;
        end
      end else begin
        m_post++;
        if (m_post == m_plat) begin m_phase = 4; m_start = (a + 1) % D; end
      end
      m_nstored++;
    end
    if (wc && avs_writedata[3] && ph0 == 2 && !ab) m_force = 1;
    if (arm) begin
      m_plat = m_plen; m_target = D - 1 - m_plat;
      m_phase = (m_target == 0) ? 2 : 1;
      m_nstored = 0; m_have_prev = 0; m_force = 0;
    end
    if (ab) m_phase = 0;
    if (wc) m_slope = avs_writedata[2];
    if (avs_write && avs_address == 3'd2) m_level = int'(avs_writedata[15:0]);
    if (avs_write && avs_address == 3'd3) m_plen = (avs_writedata > 32'(D - 1)) ? D - 1 : int'(avs_writedata[9:0]);
    if (avs_write && avs_address == 3'd5) m_rd = int'(avs_writedata[9:0]);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // compare process, away from the active edge
  initial begin
    bit ab, exp_we;
    forever begin
      @(negedge clk);
      ab = avs_write && (avs_address == 3'd0) && avs_writedata[1];
      exp_we = reset_n && sample_valid && m_phase >= 1 && m_phase <= 3 && !ab;
      chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
      if (exp_we) begin
        chk("mem_waddr", {22'd0, mem_waddr}, m_nstored % D);
        chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, sample_data});
      end
      chk("irq", {31'd0, irq}, (m_phase == 4) ? 32'd1 : 32'd0);
      chk("mem_raddr", {22'd0, mem_raddr}, m_rd);
      if (m_rchk) chk("avs_readdata", avs_readdata, m_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    d = avs_readdata;
    tick();
  endtask

  task automatic smp(input logic [15:0] v);
    sample_valid = 1'b1; sample_data = v;
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // reset state
    rd(3'd1, d); chk("status_reset", d, 32'h0000_0000);
    rd(3'd3, d); chk("post_len_reset", d, 32'h0000_0200);
    rd(3'd2, d); chk("level_reset", d, 32'h0000_8000);
    for (int i = 0; i < 4; i++) smp(16'(i + 7));
    chk("irq_reset", {31'd0, irq}, 32'd0);

    // rising trigger with ramp
    wr(3'd3, 32'd4);
    wr(3'd2, 32'd100);
    wr(3'd0, 32'h1);
    for (int i = 0; i < 1019; i++) smp(16'(i));
    rd(3'd1, d); chk("status_wait_after_1019", d, 32'h0000_0002);
    for (int i = 1019; i < 1129; i++) smp(16'(i % 1024));
    rd(3'd1, d); chk("status_done_rise", d, 32'h0064_000C);
    rd(3'd6, d); chk("start_idx_rise", d, 32'd105);
    chk("irq_done_rise", {31'd0, irq}, 32'd1);

    // readout wrap
    wr(3'd5, 32'd1023);
    rd(3'd4, d); chk("data_1023", d, 32'd1023);
    rd(3'd4, d); chk("data_0", d, 32'd0);
    rd(3'd4, d); chk("data_1", d, 32'd1);
    rd(3'd5, d); chk("rd_ptr_wrapped", d, 32'd2);

    // falling trigger, direct-to-wait, then abort mid-post
    wr(3'd2, 32'd50);
    wr(3'd3, 32'h0000_FFFF);
    rd(3'd3, d); chk("post_len_sat", d, 32'h0000_03FF);
    wr(3'd0, 32'h5);
    chk("irq_drop_on_rearm", {31'd0, irq}, 32'd0);
    rd(3'd1, d); chk("status_direct_wait", d, 32'h0064_0002);
    smp(16'd10);
    for (int v = 200; v >= 50; v--) smp(16'(v));
    rd(3'd1, d); chk("status_post_fall", d, 32'h0097_0003);
    for (int i = 0; i < 3; i++) smp(16'd7);
    sample_valid = 1'b1; sample_data = 16'd9;
    avs_address = 3'd0; avs_writedata = 32'h2; avs_write = 1'b1;
    tick();
    avs_write = 1'b0; sample_valid = 1'b0;
    tick();
    rd(3'd1, d); chk("status_abort", d, 32'h0097_0000);
    for (int i = 0; i < 3; i++) smp(16'd11);
    wr(3'd0, 32'h3);
    rd(3'd1, d); chk("status_arm_abort", d, 32'h0097_0000);

    // forced trigger with post_len 0
    wr(3'd3, 32'd0);
    rd(3'd3, d); chk("post_len_zero", d, 32'd0);
    wr(3'd0, 32'h1);
    for (int i = 0; i < 1023; i++) smp(16'd10);
    rd(3'd1, d); chk("status_wait_flat", d, 32'h0097_0002);
    for (int i = 0; i < 5; i++) smp(16'd10);
    rd(3'd1, d); chk("status_no_trig_flat", d, 32'h0097_0002);
    wr(3'd0, 32'h8);
    smp(16'd10);
    rd(3'd1, d); chk("status_force_done", d, 32'h0004_000C);
    rd(3'd6, d); chk("start_idx_force", d, 32'd5);
    chk("irq_force", {31'd0, irq}, 32'd1);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
